// File: rtl/la_pkg.sv
// Shared state encoding and trigger-position clamp constants for the
// logic-analyser capture controller (la_capture_ctrl, la_circ_ptr).
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_TRIG     = 3'd2,
    ST_DONE     = 3'd3,
    ST_DUMP_RD  = 3'd4,
    ST_DUMP_VLD = 3'd5
  } la_state_e;

  // trig_pos is clamped to [TRIG_POS_MIN, ENTRIES - TRIG_POS_TOP_GAP]
  localparam int TRIG_POS_MIN     = 1;
  localparam int TRIG_POS_TOP_GAP = 1;

endpackage

// File: rtl/la_circ_ptr.sv
// Wrapping address counter (0 .. ENTRIES-1) with clear, load and increment;
// clear beats load, load beats increment.
module la_circ_ptr #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [LOG2-1:0] i_load_val,
  input  logic            i_inc,
  output logic [LOG2-1:0] o_ptr
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  logic [LOG2-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + LOG2'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture/readout controller: circular pre/post-trigger capture
// into per-channel RAMs, then handshaked readout of one channel in age order.
// Optional macro LA_CAP_ABORT_EN: abort returns to IDLE from any state.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int SMPL_W  = 8,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wrt_smpl,
  input  logic                       trig_in,
  input  logic [LOG2-1:0]            trig_pos,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       dump,
  input  logic [$clog2(NUM_CH)-1:0]  dump_ch,
  input  logic [NUM_CH*SMPL_W-1:0]   rdata,
  input  logic                       dout_rdy,
  output logic                       we,
  output logic [LOG2-1:0]            waddr,
  output logic [LOG2-1:0]            raddr,
  output logic [SMPL_W-1:0]          dout,
  output logic                       dout_vld,
  output logic                       armed,
  output logic                       triggered,
  output logic                       capture_done,
  output logic                       dump_done
);

  localparam int              CH_W     = $clog2(NUM_CH);
  localparam logic [LOG2:0]   ENT_X    = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2:0]   CNT_LAST = (LOG2+1)'(ENTRIES - 1);
  localparam logic [LOG2-1:0] TP_MIN   = LOG2'(TRIG_POS_MIN);
  localparam logic [LOG2-1:0] TP_MAX   = LOG2'(ENTRIES - TRIG_POS_TOP_GAP);

  la_state_e         r_state;
  la_state_e         w_state_next;
  logic [LOG2:0]     r_fill;
  logic [LOG2-1:0]   r_post;
  logic [LOG2:0]     r_rd_cnt;
  logic [CH_W-1:0]   r_dump_ch;
  logic              r_dout_vld;
  logic              r_armed;
  logic              r_triggered;
  logic              r_capture_done;
  logic              r_dump_done;

  logic              w_abort;
  logic              w_arm_ok;
  logic              w_dump_ok;
  logic              w_in_cap;
  logic              w_we;
  logic              w_trig_ok;
  logic              w_hs;
  logic              w_rd_last;
  logic [LOG2-1:0]   w_tp;
  logic [SMPL_W-1:0] w_ch_data [NUM_CH];
  logic [SMPL_W-1:0] w_sel;

`ifdef LA_CAP_ABORT_EN
  assign w_abort = abort;
`else
  logic w_unused_abort;
  assign w_unused_abort = abort;
  assign w_abort        = 1'b0;
`endif

  always_comb begin
    w_tp = trig_pos;
    if (trig_pos < TP_MIN) begin
      w_tp = TP_MIN;
    end else if (trig_pos > TP_MAX) begin
      w_tp = TP_MAX;
    end
  end

  assign w_in_cap  = (r_state == ST_ARMED) || (r_state == ST_TRIG);
  assign w_we      = wrt_smpl && w_in_cap;
  assign w_arm_ok  = arm && !w_abort &&
                     (r_state inside {ST_IDLE, ST_ARMED, ST_TRIG, ST_DONE});
  // Enough history must already be stored to fill the pre-trigger window.
  assign w_trig_ok = (r_state == ST_ARMED) && wrt_smpl && trig_in &&
                     (r_fill >= (ENT_X - {1'b0, w_tp}));
  assign w_hs      = (r_state == ST_DUMP_VLD) && dout_rdy && !w_abort;
  assign w_rd_last = (r_rd_cnt == CNT_LAST);
  assign w_dump_ok = (r_state == ST_DONE) && (w_state_next == ST_DUMP_RD);

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = ST_IDLE;
    end else if (w_arm_ok) begin
      w_state_next = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_trig_ok) begin
            w_state_next = (w_tp == TP_MIN) ? ST_DONE : ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (wrt_smpl && ((r_post + LOG2'(1)) == w_tp)) begin
            w_state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          if (dump) begin
            w_state_next = ST_DUMP_RD;
          end
        end
        ST_DUMP_RD: begin
          w_state_next = ST_DUMP_VLD;
        end
        ST_DUMP_VLD: begin
          if (dout_rdy) begin
            w_state_next = w_rd_last ? ST_DONE : ST_DUMP_RD;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_fill         <= '0;
      r_post         <= '0;
      r_rd_cnt       <= '0;
      r_dump_ch      <= '0;
      r_dout_vld     <= 1'b0;
      r_armed        <= 1'b0;
      r_triggered    <= 1'b0;
      r_capture_done <= 1'b0;
      r_dump_done    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_armed        <= (w_state_next == ST_ARMED);
      r_triggered    <= (w_state_next == ST_TRIG);
      r_capture_done <= (w_state_next inside {ST_DONE, ST_DUMP_RD, ST_DUMP_VLD});
      r_dout_vld     <= (w_state_next == ST_DUMP_VLD);
      r_dump_done    <= (r_state == ST_DUMP_VLD) && (w_state_next == ST_DONE);

      if (w_arm_ok) begin
        r_fill <= '0;
      end else if (w_we && (r_fill != ENT_X)) begin
        r_fill <= r_fill + (LOG2+1)'(1);
      end

      // The trigger sample itself is post-trigger sample 1.
      if (r_state == ST_ARMED) begin
        r_post <= LOG2'(1);
      end else if ((r_state == ST_TRIG) && wrt_smpl) begin
        r_post <= r_post + LOG2'(1);
      end

      if (w_dump_ok) begin
        r_dump_ch <= dump_ch;
        r_rd_cnt  <= '0;
      end else if (w_hs) begin
        r_rd_cnt  <= r_rd_cnt + (LOG2+1)'(1);
      end
    end
  end

  la_circ_ptr #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_wptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_arm_ok),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_we),
    .o_ptr      (waddr)
  );

  // After a completed capture the write pointer addresses the oldest sample.
  la_circ_ptr #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_rptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (1'b0),
    .i_load     (w_dump_ok),
    .i_load_val (waddr),
    .i_inc      (w_hs),
    .o_ptr      (raddr)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_data[gi] = rdata[gi*SMPL_W +: SMPL_W];
    end
  endgenerate

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_dump_ch == CH_W'(i)) begin
        w_sel = w_ch_data[i];
      end
    end
  end

  assign we           = w_we;
  assign dout         = r_dout_vld ? w_sel : '0;
  assign dout_vld     = r_dout_vld;
  assign armed        = r_armed;
  assign triggered    = r_triggered;
  assign capture_done = r_capture_done;
  assign dump_done    = r_dump_done;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: table of capture/dump scenarios plus
// reset and abort sequences; a behavioural RAM with registered read.
module tb_la_capture_ctrl;

  localparam int NUM_CH  = 5;
  localparam int SMPL_W  = 8;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int CH_W    = 3;
  localparam int NVEC    = 6;

  logic                     clk      = 1'b0;
  logic                     rst_n    = 1'b0;
  logic                     wrt_smpl = 1'b0;
  logic                     trig_in  = 1'b0;
  logic [LOG2-1:0]          trig_pos = '0;
  logic                     arm      = 1'b0;
  logic                     abort    = 1'b0;
  logic                     dump     = 1'b0;
  logic [CH_W-1:0]          dump_ch  = '0;
  logic [NUM_CH*SMPL_W-1:0] rdata;
  logic                     dout_rdy = 1'b0;
  logic                     we;
  logic [LOG2-1:0]          waddr;
  logic [LOG2-1:0]          raddr;
  logic [SMPL_W-1:0]        dout;
  logic                     dout_vld;
  logic                     armed;
  logic                     triggered;
  logic                     capture_done;
  logic                     dump_done;

  int checks = 0;
  int errors = 0;
  int sample_no = 0;
  logic [SMPL_W-1:0] mem [NUM_CH][512];

  typedef struct {
    int tp;             // trig_pos driven
    int pre;            // write index from which trig_in is held high
    int ch;             // channel dumped
    int rdy_div;        // dout_rdy high one cycle in rdy_div
    int exp_trig;       // write index at which the trigger is accepted
    int exp_writes;     // total writes until DONE
    int exp_waddr;      // waddr (oldest sample) at DONE
    int exp_trig_state; // 1 if TRIG state is visited
  } vec_t;

  vec_t vecs [NVEC];

  la_capture_ctrl #(
    .NUM_CH  (NUM_CH),
    .SMPL_W  (SMPL_W),
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrt_smpl     (wrt_smpl),
    .trig_in      (trig_in),
    .trig_pos     (trig_pos),
    .arm          (arm),
    .abort        (abort),
    .dump         (dump),
    .dump_ch      (dump_ch),
    .rdata        (rdata),
    .dout_rdy     (dout_rdy),
    .we           (we),
    .waddr        (waddr),
    .raddr        (raddr),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done),
    .dump_done    (dump_done)
  );

  always #5 clk = ~clk;

  function automatic logic [SMPL_W-1:0] smpl_val(input int n, input int c);
    int v;
    v = (n * 5 + c * 37) ^ (n >>> 8);
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < NUM_CH; c++) mem[c][waddr] <= smpl_val(sample_no, c);
      sample_no <= sample_no + 1;
    end
    for (int c = 0; c < NUM_CH; c++) rdata[c*SMPL_W +: SMPL_W] <= mem[c][raddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"},           int'(we),           0);
    chk({tag, ".waddr"},        int'(waddr),        0);
    chk({tag, ".raddr"},        int'(raddr),        0);
    chk({tag, ".dout"},         int'(dout),         0);
    chk({tag, ".dout_vld"},     int'(dout_vld),     0);
    chk({tag, ".armed"},        int'(armed),        0);
    chk({tag, ".triggered"},    int'(triggered),    0);
    chk({tag, ".capture_done"}, int'(capture_done), 0);
    chk({tag, ".dump_done"},    int'(dump_done),    0);
  endtask

  task automatic run_capture(input int vi, output int base);
    int  trig_cnt;
    int  done_cnt;
    bit  seen_arm;
    bit  seen_trig;
    trig_cnt  = -1;
    done_cnt  = -1;
    seen_arm  = 1'b0;
    seen_trig = 1'b0;
    trig_pos  = LOG2'(vecs[vi].tp);
    @(posedge clk); #1;
    arm = 1'b1; wrt_smpl = 1'b0; trig_in = 1'b0;
    @(posedge clk); #1;
    arm  = 1'b0;
    base = sample_no;
    for (int cyc = 0; cyc < 4000 && done_cnt < 0; cyc++) begin
      wrt_smpl = 1'b1;
      trig_in  = ((sample_no - base) >= vecs[vi].pre);
      @(negedge clk);
      if (armed) seen_arm = 1'b1;
      if (triggered) seen_trig = 1'b1;
      if (seen_arm && !armed && trig_cnt < 0) trig_cnt = sample_no - base;
      if (capture_done) done_cnt = sample_no - base;
      @(posedge clk); #1;
    end
    chk("armed_seen", int'(seen_arm), 1);
    chk("trig_write", trig_cnt - 1, vecs[vi].exp_trig);
    chk("trig_state_seen", int'(seen_trig), vecs[vi].exp_trig_state);
    chk("done_writes", done_cnt, vecs[vi].exp_writes);
    chk("done_waddr", int'(waddr), vecs[vi].exp_waddr);
    repeat (5) @(posedge clk);
    #1;
    chk("no_write_after_done", sample_no - base, vecs[vi].exp_writes);
    wrt_smpl = 1'b0;
    trig_in  = 1'b0;
    $display("CAPTURE vec=%0d tp=%0d trig_write=%0d writes=%0d waddr=%0d",
             vi, vecs[vi].tp, trig_cnt - 1, done_cnt, waddr);
  endtask

  task automatic run_dump(input int ch, input int rdy_div, input int base,
                          input int writes, input int raddr0);
    int k;
    int dd;
    bit pend;
    logic [SMPL_W-1:0] prev;
    k    = 0;
    dd   = 0;
    pend = 1'b0;
    prev = '0;
    @(posedge clk); #1;
    dump_ch = CH_W'(ch); dump = 1'b1; dout_rdy = 1'b0;
    @(posedge clk); #1;
    dump = 1'b0;
    for (int cyc = 0; cyc < 6000 && dd == 0; cyc++) begin
      dout_rdy = ((cyc % rdy_div) == 0);
      @(negedge clk);
      if (dump_done) dd++;
      if (dout_vld) begin
        chk("dump_data", int'(dout), int'(smpl_val(base + writes - ENTRIES + k, ch)));
        chk("dump_raddr", int'(raddr), (raddr0 + k) % ENTRIES);
        if (pend) chk("dout_hold", int'(dout), int'(prev));
        prev = dout;
        if (dout_rdy) begin
          k++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    dout_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (dump_done) dd++;
    end
    chk("dump_handshakes", k, ENTRIES);
    chk("dump_done_pulses", dd, 1);
    chk("vld_after_dump", int'(dout_vld), 0);
    chk("done_after_dump", int'(capture_done), 1);
    @(posedge clk); #1;
    dout_rdy = 1'b0;
    $display("DUMP ch=%0d rdy_div=%0d start_raddr=%0d handshakes=%0d dump_done=%0d",
             ch, rdy_div, raddr0, k, dd);
  endtask

  initial begin
    int base;
    int got;
    //            tp   pre  ch div trig writes waddr trigst
    vecs[0] = '{128,    0, 0, 1,  256,  384,    0, 1};
    vecs[1] = '{100, 1000, 4, 3, 1000, 1100,  332, 1};
    vecs[2] = '{  0,    0, 2, 2,  383,  384,    0, 0};
    vecs[3] = '{511,    0, 1, 1,    1,  384,    0, 1};
    vecs[4] = '{  1,  500, 3, 1,  500,  501,  117, 0};
    vecs[5] = '{383,   10, 4, 2,   10,  393,    9, 1};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int vi = 0; vi < NVEC; vi++) begin
      run_capture(vi, base);
      run_dump(vecs[vi].ch, vecs[vi].rdy_div, base, vecs[vi].exp_writes, vecs[vi].exp_waddr);
      if (vi == 0) begin
        run_dump(3, 1, base, vecs[vi].exp_writes, vecs[vi].exp_waddr);
      end
    end

    // Asynchronous reset while a sample is being presented.
    run_capture(0, base);
    @(posedge clk); #1;
    dump_ch = 3'd4; dump = 1'b1; dout_rdy = 1'b0;
    @(posedge clk); #1;
    dump = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      got = int'(dout_vld);
    end
    chk("reach_dump_vld", got, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 chk_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Dump outside DONE is ignored.
    @(posedge clk); #1;
    dump = 1'b1;
    @(posedge clk); #1;
    dump = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("dump_in_idle_vld", int'(dout_vld), 0);
    chk("dump_in_idle_done", int'(capture_done), 0);

    // arm and abort in the same cycle.
    @(posedge clk); #1;
    arm = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    @(negedge clk);
`ifdef LA_CAP_ABORT_EN
    chk_zero("arm_abort");
`else
    chk("arm_abort_armed", int'(armed), 1);
`endif

    // abort during capture.
    @(posedge clk); #1;
    arm = 1'b1; wrt_smpl = 1'b0;
    @(posedge clk); #1;
    arm = 1'b0; wrt_smpl = 1'b1; trig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
`ifdef LA_CAP_ABORT_EN
    chk("abort_cap_armed", int'(armed), 0);
    chk("abort_cap_we", int'(we), 0);
`else
    chk("abort_cap_armed", int'(armed), 1);
    chk("abort_cap_we", int'(we), 1);
`endif
    wrt_smpl = 1'b0;
    $display("SEQ reset_abort done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_capture_ctrl.md
LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of sample channels sharing one write/read address.
REQ-002 SHALL have parameter SMPL_W, default 8, bits per channel RAM word.
REQ-003 SHALL have parameter ENTRIES, default 384, RAM depth per channel.
REQ-004 SHALL have parameter LOG2, default 9, address width; ENTRIES <= 2^LOG2.
REQ-005 SHALL have port clk  input  1  system clock; the block has one clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port wrt_smpl  input  1  sample strobe, one cycle per decimated sample.
REQ-008 SHALL have port trig_in  input  1  qualified trigger from trigger logic.
REQ-009 SHALL have port trig_pos  input  LOG2  samples kept from trigger inclusive.
REQ-010 SHALL have port arm  input  1  start-capture pulse.
REQ-011 SHALL have port abort  input  1  cancel pulse.
REQ-012 SHALL have port dump  input  1  start-readout pulse.
REQ-013 SHALL have port dump_ch  input  $clog2(NUM_CH)  channel to read out.
REQ-014 SHALL have port rdata  input  NUM_CH*SMPL_W  RAM read data, channel 0 in LSBs.
REQ-015 SHALL have port dout_rdy  input  1  consumer accepts dout.
REQ-016 SHALL have port we  output  1  RAM write enable, common to all channels.
REQ-017 SHALL have port waddr  output  LOG2  RAM write address.
REQ-018 SHALL have port raddr  output  LOG2  RAM read address.
REQ-019 SHALL have port dout  output  SMPL_W  readout sample.
REQ-020 SHALL have port dout_vld  output  1  dout valid.
REQ-021 SHALL have ports armed, triggered, capture_done, dump_done  output  1 each  status; dump_done is a one-cycle pulse.

Function
REQ-022 SHALL implement states IDLE, ARMED, TRIG, DONE, DUMP_RD, DUMP_VLD.
REQ-023 SHALL, on arm in IDLE/ARMED/TRIG/DONE, clear waddr and fill count and enter ARMED; arm in DUMP_* is ignored.
REQ-024 SHALL drive we = wrt_smpl in ARMED/TRIG (combinational, same cycle), else 0.
REQ-025 SHALL advance waddr by one after each write, wrapping ENTRIES-1 -> 0.
REQ-026 SHALL keep a fill count saturating at ENTRIES.
REQ-027 SHALL treat trig_pos = 0 as 1 and trig_pos >= ENTRIES as ENTRIES-1.
REQ-028 SHALL accept trig_in only on a wrt_smpl cycle in ARMED with fill >= ENTRIES-trig_pos; that sample is post-trigger sample 1; state -> TRIG.
REQ-029 SHALL, in TRIG, enter DONE on the write cycle of post-trigger sample trig_pos (trig_pos=1 -> ARMED to DONE directly).
REQ-030 SHALL hold capture_done high in DONE and DUMP_*; armed high in ARMED; triggered high in TRIG.
REQ-031 SHALL, on dump in DONE, latch dump_ch, set raddr = waddr (oldest sample), and enter DUMP_RD; dump elsewhere ignored.
REQ-032 SHALL, in DUMP_RD, wait one cycle for RAM latency and enter DUMP_VLD presenting dout = selected rdata slice with dout_vld = 1.
REQ-033 SHALL hold dout/dout_vld stable until dout_rdy, then advance raddr (wrapping) and return to DUMP_RD.
REQ-034 SHALL, after ENTRIES accepted samples, pulse dump_done and return to DONE; repeated dumps are allowed.
REQ-035 SHALL give abort priority over arm, dump, and trigger in the same cycle.

Reset
REQ-036 SHALL, on rst_n low, asynchronously enter IDLE with we, waddr, raddr, dout, dout_vld, armed, triggered, capture_done, and dump_done all 0, including mid-capture or mid-dump.

Configuration
REQ-037 SHALL, with LA_CAP_ABORT_EN defined, return to IDLE from any state on abort (dout_vld dropped, no dump_done); without it, abort is ignored and the port remains present.

Structure
REQ-038 SHALL take the state enum typedef and the trig_pos clamp constants from shared package la_pkg.
REQ-039 SHALL contain one sub-module la_circ_ptr (wrapping address counter), instantiated for waddr and raddr.

Verification
REQ-040 ENTRIES=384, trig_pos=128, trig_in held, wrt_smpl every cycle -> trigger accepted at write 256, DONE after write 383, we count 384.
REQ-041 Run 1000 samples before trigger with trig_pos=100 -> dump starts at raddr = waddr, 384 samples in age order with wrap 383 -> 0.
REQ-042 dout_rdy toggled 1-of-3 cycles during dump -> dout stable while not accepted, exactly 384 handshakes, one dump_done.
REQ-043 dump_ch=4, NUM_CH=5 -> dout equals rdata[39:32] for every sample.
REQ-044 rst_n low mid-DUMP_VLD, then arm and abort in the same cycle with LA_CAP_ABORT_EN -> all outputs 0, state IDLE.
REQ-045 trig_pos=0 and trig_pos=511 -> behave as 1 and 383 respectively.
